fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller between the PC/redirect logic and a single-port instruction memory with request/grant/response handshake.
- Sequences one outstanding fetch at a time and holds the returned instruction in a one-entry output register until decode accepts it.
- Applies branch/jump redirects from execute, discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- ADDR_W, 32, address/PC width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored (treated as 00).
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; word aligned.
- imem_gnt  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  response instruction word.
- instr_valid  out  1  output register holds an instruction.
- instr  out  32  held instruction.
- instr_pc  out  ADDR_W  address of held instruction.
- instr_ready  in  1  decode accepts instruction this cycle.

Behaviour:
- Reset values: state=IDLE, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, drop=0. Reset mid-operation aborts everything immediately; no response is retained.
- All outputs are registered. No combinational path from inputs to outputs.
- States:
  - IDLE: one cycle after reset deassertion; -> REQ with imem_addr=RESET_PC.
  - REQ: imem_req=1. On imem_gnt -> WAIT.
  - WAIT: imem_req=0. On imem_rvalid with drop=0: instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1 -> HOLD. On imem_rvalid with drop=1: discard, drop<=0, imem_addr<=stored target -> REQ.
  - HOLD: on instr_ready: instr_valid<=0, imem_addr<=instr_pc+4 -> REQ.
- Single outstanding request. Best-case throughput is one instruction per 3 cycles (REQ, WAIT, HOLD) with 1-cycle grant and response.
- imem_rvalid in IDLE/REQ/HOLD is ignored.
- Next address is instr_pc+4 modulo 2^ADDR_W (32'hFFFFFFFC -> 32'h0).
- Redirect handling (redirect_valid=1), target T = {redirect_pc[ADDR_W-1:2],2'b00}:
  - IDLE: imem_addr<=T; -> REQ.
  - REQ without gnt: imem_addr<=T next cycle, imem_req stays 1 (memory permits address change before grant).
  - REQ with gnt same cycle: old request is in flight; drop<=1, target<=T -> WAIT.
  - WAIT with rvalid same cycle: response discarded; imem_addr<=T -> REQ.
  - WAIT without rvalid: drop<=1, target<=T; stay in WAIT. Later redirects overwrite target (latest wins).
  - HOLD: instr_valid<=0, imem_addr<=T -> REQ. If instr_ready is also high that cycle, the handshake counts as a completed transfer; execute is responsible for squashing it.
- A redirect always takes priority over the sequential instr_pc+4 path.
- Output register contents (instr, instr_pc) are stable while instr_valid=1 and instr_ready=0.

Test Plan:
- Reset with RESET_PC=32'h100, then memory grants and responds each cycle with instr_ready=1 -> imem_addr sequence 0x100, 0x104, 0x108; instr_valid pulses every 3 cycles with instr_pc matching each address.
- Hold instr_ready=0 for 5 cycles in HOLD -> instr and instr_pc stable, imem_req=0 throughout; first instr_ready=1 -> REQ with addr = instr_pc+4.
- redirect_valid with redirect_pc=32'h203 while in WAIT, rvalid 3 cycles later (data 0xDEADBEEF) -> 0xDEADBEEF never appears on instr; next imem_addr=0x200.
- Two redirects (0x300 then 0x400) during one WAIT -> stale response dropped; next fetch at 0x400.
- Fetch at 32'hFFFFFFFC accepted -> next imem_addr=32'h00000000.
- Assert reset during WAIT, then send rvalid after release -> all outputs return to reset values; stray rvalid ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - single-outstanding instruction fetch sequencer with redirect and stale-response drop
//
// Ports:
//   clk, reset                    clock (rising edge), asynchronous active-high reset
//   redirect_valid, redirect_pc   taken branch/jump from execute and its target
//   imem_req, imem_addr           fetch request and word-aligned fetch address (registered)
//   imem_gnt                      memory accepted the request this cycle
//   imem_rvalid, imem_rdata       fetch response
//   instr_valid, instr, instr_pc  one-entry output register toward decode (registered)
//   instr_ready                   decode accepts the held instruction this cycle

module fetch_sequencer #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam logic [ADDR_W-1:0] START_PC = {RESET_PC[ADDR_W-1:2], 2'b00};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              drop, drop_nxt;
    logic [ADDR_W-1:0] target, target_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              valid_nxt;
    logic              capture;
    logic [ADDR_W-1:0] redir_tgt;

    // Low target bits are forced to zero; the raw bits are intentionally dropped.
    logic unused_redir_lsbs;
    assign unused_redir_lsbs = ^redirect_pc[1:0];
    assign redir_tgt         = {redirect_pc[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_nxt  = state;
        addr_nxt   = imem_addr;
        drop_nxt   = drop;
        target_nxt = target;
        valid_nxt  = instr_valid;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
                addr_nxt  = redirect_valid ? redir_tgt : START_PC;
            end
            S_REQ: begin
                if (imem_gnt) begin
                    state_nxt = S_WAIT;
                    // The old address is already in flight; remember to discard its response.
                    if (redirect_valid) begin
                        drop_nxt   = 1'b1;
                        target_nxt = redir_tgt;
                    end
                end else if (redirect_valid) begin
                    // Memory allows retargeting an ungranted request.
                    addr_nxt = redir_tgt;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_valid) begin
                        addr_nxt  = redir_tgt;
                        drop_nxt  = 1'b0;
                        state_nxt = S_REQ;
                    end else if (drop) begin
                        addr_nxt  = target;
                        drop_nxt  = 1'b0;
                        state_nxt = S_REQ;
                    end else begin
                        capture   = 1'b1;
                        valid_nxt = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    // Latest redirect wins while waiting on a stale response.
                    drop_nxt   = 1'b1;
                    target_nxt = redir_tgt;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    valid_nxt = 1'b0;
                    addr_nxt  = redir_tgt;
                    state_nxt = S_REQ;
                end else if (instr_ready) begin
                    valid_nxt = 1'b0;
                    addr_nxt  = instr_pc + ADDR_W'(4);
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_req    <= 1'b0;
            imem_addr   <= START_PC;
            drop        <= 1'b0;
            target      <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            // Request line mirrors the next state so it is registered yet aligned with REQ.
            imem_req    <= (state_nxt == S_REQ);
            imem_addr   <= addr_nxt;
            drop        <= drop_nxt;
            target      <= target_nxt;
            instr_valid <= valid_nxt;
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= imem_addr;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard testbench for fetch_sequencer

module tb_fetch_sequencer;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard entries: {pc, data}
    logic [63:0] sb_q[$];

    // Memory / stimulus model
    logic        redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        rdy = 1'b0;
    logic        gnt_en = 1'b1;
    int          rsp_delay = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_cnt = 0;
    logic        pend_stale = 1'b0;
    logic [31:0] exp_fetch = RPC;
    logic [31:0] last_pc = '0;
    int          n_xfer = 0;
    logic        seen_beef = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic cycle();
        logic [63:0] e;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = redir;
        redirect_pc    = redir_pc;
        instr_ready    = rdy;
        if (pend) begin
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                if (pend_stale || redir) begin
                    imem_rdata = 32'hDEAD_BEEF;
                end else begin
                    imem_rdata = mem_word(pend_addr);
                    sb_q.push_back({pend_addr, imem_rdata});
                end
                pend = 1'b0;
            end else begin
                pend_cnt--;
                if (redir) pend_stale = 1'b1;
            end
        end else if (imem_req && gnt_en) begin
            imem_gnt = 1'b1;
            check("gnt_addr", imem_addr, exp_fetch);
            pend       = 1'b1;
            pend_addr  = imem_addr;
            pend_cnt   = rsp_delay;
            pend_stale = redir;
        end
        if (instr_valid && instr == 32'hDEAD_BEEF) seen_beef = 1'b1;
        if (instr_valid) begin
            if (rdy) begin
                if (sb_q.size() == 0) begin
                    check("sb_empty", 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("xfer_pc", instr_pc, e[63:32]);
                    check("xfer_instr", instr, e[31:0]);
                    exp_fetch = e[63:32] + 32'd4;
                    last_pc   = e[63:32];
                end
                n_xfer++;
            end else if (redir && sb_q.size() != 0) begin
                void'(sb_q.pop_front());
            end
        end
        if (redir) exp_fetch = {redir_pc[31:2], 2'b00};
        redir = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [31:0] h_instr, h_pc;
        logic        stable;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, RPC);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_pc", instr_pc, 0);
        reset = 1'b0;

        // Back-to-back sequential fetches, one per 3 cycles
        rdy = 1'b1;
        cycle();
        n_xfer = 0;
        repeat (9) cycle();
        check("thru_xfers", n_xfer, 3);

        // Decode stall in HOLD
        rdy = 1'b0;
        n = 0;
        while (!instr_valid && n < 20) begin cycle(); n++; end
        check("hold_reach", (n < 20), 1);
        h_instr = instr;
        h_pc    = instr_pc;
        stable  = 1'b1;
        repeat (5) begin
            cycle();
            if (instr !== h_instr || instr_pc !== h_pc || imem_req !== 1'b0 || instr_valid !== 1'b1)
                stable = 1'b0;
        end
        check("hold_stable", stable, 1);
        rdy = 1'b1;
        cycle();
        check("hold_rel_req", imem_req, 1);
        check("hold_rel_addr", imem_addr, h_pc + 32'd4);

        // Redirect during WAIT, late stale response
        rsp_delay = 3;
        n = 0;
        while (!pend && n < 20) begin cycle(); n++; end
        redir = 1'b1; redir_pc = 32'h0000_0203;
        cycle();
        rsp_delay = 0;
        n = 0;
        while (pend && n < 20) begin cycle(); n++; end
        check("redir_req", imem_req, 1);
        check("redir_addr", imem_addr, 32'h0000_0200);
        repeat (6) cycle();

        // Two redirects in one WAIT, latest wins
        rsp_delay = 4;
        n = 0;
        while (!pend && n < 20) begin cycle(); n++; end
        redir = 1'b1; redir_pc = 32'h0000_0300;
        cycle();
        redir = 1'b1; redir_pc = 32'h0000_0400;
        cycle();
        rsp_delay = 0;
        n = 0;
        while (pend && n < 20) begin cycle(); n++; end
        check("redir2_addr", imem_addr, 32'h0000_0400);
        repeat (6) cycle();

        // Address wrap at top of address space
        n = 0;
        while (!instr_valid && n < 20) begin cycle(); n++; end
        redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
        cycle();
        n = 0;
        while (last_pc != 32'hFFFF_FFFC && n < 20) begin cycle(); n++; end
        check("wrap_reach", (n < 20), 1);
        check("wrap_addr", imem_addr, 32'h0000_0000);
        repeat (3) cycle();

        // Reset during WAIT, then a stray response
        rsp_delay = 3;
        n = 0;
        while (!pend && n < 20) begin cycle(); n++; end
        reset = 1'b1;
        #1;
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_valid", instr_valid, 0);
        check("mid_rst_addr", imem_addr, RPC);
        check("mid_rst_instr", instr, 0);
        check("mid_rst_pc", instr_pc, 0);
        sb_q.delete();
        pend = 1'b0; exp_fetch = RPC; rsp_delay = 0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        check("stray_valid", instr_valid, 0);
        check("restart_req", imem_req, 1);
        check("restart_addr", imem_addr, RPC);
        n_xfer = 0;
        repeat (6) cycle();
        check("restart_xfers", n_xfer, 2);
        check("no_stale_data", seen_beef, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
